// File: rtl/tri_bus_scheduler.sv
// tri_bus_scheduler: round-robin owner selection for one shared tri-state bus,
// with a bounded hold time and an all-'z turnaround between owners.
module tri_bus_scheduler #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 24,
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYC = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   gnt_id,
    output tri   [WIDTH-1:0]           bus,
    output logic                       busy,
    output logic                       hold_expired
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        TURN
    } state_t;

    state_t           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [IW-1:0]    gnt_id_q;
    logic             busy_q;
    logic             hold_q;
    logic [IW-1:0]    ptr_q;
    logic [CW-1:0]    cnt_q;
    logic [TW-1:0]    tcnt_q;

    logic             arb_hit;
    logic [IW-1:0]    arb_id;
    logic [IW-1:0]    arb_ptr;

    // Round-robin search: first requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        int p;
        p       = 0;
        arb_hit = 1'b0;
        arb_id  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            p = int'(ptr_q) + k;
            if (p >= N_REQ) begin
                p = p - N_REQ;
            end
            if (!arb_hit && req[p]) begin
                arb_hit = 1'b1;
                arb_id  = IW'(p);
            end
        end
        arb_ptr = (arb_id == IW'(N_REQ - 1)) ? '0 : arb_id + IW'(1);
    end

    // Ownership FSM; every output comes straight from a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
            hold_q   <= 1'b0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            tcnt_q   <= '0;
        end else begin
            hold_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (arb_hit) begin
                        state_q  <= OWN;
                        gnt_q    <= N_REQ'(1) << arb_id;
                        gnt_id_q <= arb_id;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        ptr_q    <= arb_ptr;
                    end
                end
                OWN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (!req[gnt_id_q] || cnt_q == CW'(MAX_HOLD - 1)) begin
                        state_q <= TURN;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        tcnt_q  <= '0;
                        // a voluntary release never counts as an expiry
                        hold_q  <= req[gnt_id_q];
                    end
                end
                TURN: begin
                    if (tcnt_q == TW'(TURN_CYC - 1)) begin
                        if (arb_hit) begin
                            state_q  <= OWN;
                            gnt_q    <= N_REQ'(1) << arb_id;
                            gnt_id_q <= arb_id;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            ptr_q    <= arb_ptr;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt          = gnt_q;
    assign gnt_id       = gnt_id_q;
    assign busy         = busy_q;
    assign hold_expired = hold_q;

    // Only the registered owner ever enables a driver onto the shared net.
    assign bus = busy_q ? req_data[gnt_id_q*WIDTH +: WIDTH] : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tri_bus_scheduler.sv
// Bench for tri_bus_scheduler: two configurations (4 req/turn 1/hold 8 and
// 3 req/turn 3/hold 4) checked every cycle against an ownership model.
module tb_tri_bus_scheduler;

    localparam int W  = 24;
    localparam int NA = 4;
    localparam int TA = 1;
    localparam int MA = 8;
    localparam int NB = 3;
    localparam int TB = 3;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NA-1:0] req_a = '0;
    logic [NA*W-1:0] rd_a = '0;
    logic [NA-1:0] gnt_a;
    logic [1:0]    id_a;
    wire  [W-1:0]  bus_a;
    logic          busy_a;
    logic          hx_a;
    logic [NB-1:0] req_b = '0;
    logic [NB*W-1:0] rd_b = '0;
    logic [NB-1:0] gnt_b;
    logic [1:0]    id_b;
    wire  [W-1:0]  bus_b;
    logic          busy_b;
    logic          hx_b;

    always #5 clk = ~clk;

    tri_bus_scheduler #(.N_REQ(NA), .WIDTH(W), .MAX_HOLD(MA), .TURN_CYC(TA)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .req_data(rd_a), .gnt(gnt_a),
        .gnt_id(id_a), .bus(bus_a), .busy(busy_a), .hold_expired(hx_a)
    );

    tri_bus_scheduler #(.N_REQ(NB), .WIDTH(W), .MAX_HOLD(MB), .TURN_CYC(TB)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_data(rd_b), .gnt(gnt_b),
        .gnt_id(id_b), .bus(bus_b), .busy(busy_b), .hold_expired(hx_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_z(input string nm, input logic [W-1:0] b);
        n_tests++;
        if (!(b === {W{1'bz}} || b === '0)) begin
            n_fail++;
            $display("FAIL %s: bus driven %0h expected all-z (t=%0t)", nm, b, $time);
        end
    endtask

    // Model: who owns the bus, for how many cycles so far, remaining
    // turnaround cycles, and the next round-robin start point.
    int m_own[2];
    int m_run[2];
    int m_gap[2];
    int m_ptr[2];
    bit m_hx[2];
    int o_last[2];
    int o_zr[2];
    int o_run[2];

    task automatic m_reset(input int k);
        m_own[k] = -1; m_run[k] = 0; m_gap[k] = 0; m_ptr[k] = 0; m_hx[k] = 0;
        o_last[k] = -1; o_zr[k] = 0; o_run[k] = 0;
    endtask

    task automatic m_step(input int k, input int n, input int t, input int mx,
                          input logic [15:0] r);
        bit arb;
        arb = 0;
        m_hx[k] = 0;
        if (m_own[k] >= 0) begin
            if (!r[m_own[k]]) begin
                m_own[k] = -1; m_gap[k] = t;
            end else if (m_run[k] == mx) begin
                m_own[k] = -1; m_gap[k] = t; m_hx[k] = 1;
            end else begin
                m_run[k]++;
            end
        end else if (m_gap[k] > 0) begin
            m_gap[k]--;
            arb = (m_gap[k] == 0);
        end else begin
            arb = 1;
        end
        if (arb) begin
            for (int j = 0; j < n; j++) begin
                int i;
                i = (m_ptr[k] + j) % n;
                if (r[i]) begin
                    m_own[k] = i; m_run[k] = 1; m_ptr[k] = (i + 1) % n;
                    break;
                end
            end
        end
    endtask

    task automatic check_inst(input int k, input int t, input int mx,
                              input logic [15:0] g, input logic [1:0] id,
                              input logic b, input logic h,
                              input logic [W-1:0] bv, input logic [16*W-1:0] rd);
        logic [15:0] eg;
        string p;
        int o;
        p  = (k == 0) ? "A" : "B";
        eg = (m_own[k] >= 0) ? (16'd1 << m_own[k]) : 16'd0;
        chk({p, ".gnt"}, 32'(g), 32'(eg));
        chk({p, ".busy"}, 32'(b), 32'(m_own[k] >= 0));
        chk({p, ".hold_expired"}, 32'(h), 32'(m_hx[k]));
        chk({p, ".onehot0"}, 32'($onehot0(g)), 32'd1);
        if (m_own[k] >= 0) begin
            chk({p, ".gnt_id"}, 32'(id), 32'(m_own[k]));
            chk({p, ".bus"}, 32'(bv), 32'(rd[m_own[k]*W +: W]));
        end else begin
            chk_z({p, ".bus_z"}, bv);
        end
        // invariants on the observed grant stream
        if (g == 0) begin
            o_zr[k]++;
            o_run[k] = 0;
        end else begin
            o = 0;
            for (int i = 0; i < 16; i++) if (g[i]) o = i;
            if (o == o_last[k] && o_zr[k] == 0) begin
                o_run[k]++;
            end else begin
                if (o_last[k] >= 0 && o != o_last[k])
                    chk({p, ".turn_gap"}, 32'(o_zr[k] >= t), 32'd1);
                o_run[k] = 1;
            end
            chk({p, ".max_hold"}, 32'(o_run[k] <= mx), 32'd1);
            o_zr[k] = 0;
            o_last[k] = o;
        end
    endtask

    // Single compare process: advance the model on each edge, check #1 later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reset(0);
            m_reset(1);
        end else begin
            m_step(0, NA, TA, MA, 16'(req_a));
            m_step(1, NB, TB, MB, 16'(req_b));
        end
        #1;
        check_inst(0, TA, MA, 16'(gnt_a), id_a, busy_a, hx_a, bus_a, (16*W)'(rd_a));
        check_inst(1, TB, MB, 16'(gnt_b), id_b, busy_b, hx_b, bus_b, (16*W)'(rd_b));
    end

    task automatic cyc(input logic [3:0] ra, input logic [2:0] rb);
        @(negedge clk);
        req_a = ra;
        req_b = rb;
        for (int i = 0; i < NA; i++) rd_a[i*W +: W] = W'($urandom);
        for (int i = 0; i < NB; i++) rd_b[i*W +: W] = W'($urandom);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        req_a = '0;
        req_b = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] ra;
        logic [2:0] rb;
        do_reset();
        chk("reset.gnt", 32'(gnt_a), 32'd0);
        chk("reset.busy", 32'(busy_a), 32'd0);
        chk("reset.hx", 32'(hx_a), 32'd0);
        chk("reset.id", 32'(id_a), 32'd0);

        // single request from IDLE, then ptr=3 favours 3 over 0
        cyc(4'b0100, 3'b000);
        chk("t1.gnt", 32'(gnt_a), 32'h4);
        chk("t1.id", 32'(id_a), 32'd2);
        chk("t1.busy", 32'(busy_a), 32'd1);
        chk("t1.bus", 32'(bus_a), 32'(rd_a[71:48]));
        cyc(4'b0000, 3'b000);
        cyc(4'b1001, 3'b000);
        chk("t1.ptr3", 32'(gnt_a), 32'h8);

        // all requesting: rotation with forced hand-off every 8 cycles
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            cyc(4'b1111, 3'b000);
            if (e == 1)  chk("t2.first", 32'(gnt_a), 32'h1);
            if (e == 8)  chk("t2.last0", 32'(gnt_a), 32'h1);
            if (e == 9)  chk("t2.expire", 32'({busy_a, hx_a}), 32'b01);
            if (e == 10) chk("t2.next1", 32'(gnt_a), 32'h2);
            if (e == 28) chk("t2.own3", 32'(gnt_a), 32'h8);
            if (e == 37) chk("t2.wrap0", 32'(gnt_a), 32'h1);
        end

        // release coinciding with hold limit: one turnaround, no expiry
        do_reset();
        for (int e = 1; e <= 8; e++) cyc(4'b0010, 3'b000);
        cyc(4'b0000, 3'b000);
        chk("t3.rel", 32'({busy_a, hx_a}), 32'b00);
        cyc(4'b0001, 3'b000);
        chk("t3.single_turn", 32'(gnt_a), 32'h1);

        // ptr=1 with 1001: owner 3 first, then 0
        do_reset();
        cyc(4'b0001, 3'b000);
        cyc(4'b1000, 3'b000);
        cyc(4'b1001, 3'b000);
        chk("t4.first3", 32'(gnt_a), 32'h8);
        for (int e = 4; e <= 11; e++) cyc(4'b1001, 3'b000);
        chk("t4.expire", 32'({busy_a, hx_a}), 32'b01);
        cyc(4'b1001, 3'b000);
        chk("t4.then0", 32'(gnt_a), 32'h1);

        // asynchronous reset mid-ownership
        do_reset();
        cyc(4'b0100, 3'b000);
        cyc(4'b0100, 3'b000);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5.gnt", 32'(gnt_a), 32'd0);
        chk("t5.busy", 32'(busy_a), 32'd0);
        chk_z("t5.bus", bus_a);
        #5 rst = 1'b0;
        cyc(4'b1010, 3'b000);
        chk("t5.ptr0", 32'(gnt_a), 32'h2);
        chk("t5.id", 32'(id_a), 32'd1);

        // 3 requesters, 3-cycle turnaround, 2 -> 0 hand-off
        do_reset();
        cyc(4'b0000, 3'b100);
        chk("t6.own2", 32'({gnt_b, id_b}), 32'({3'b100, 2'd2}));
        cyc(4'b0000, 3'b011);
        chk("t6.z1", 32'(busy_b), 32'd0);
        cyc(4'b0000, 3'b011);
        cyc(4'b0000, 3'b011);
        chk("t6.z3", 32'(busy_b), 32'd0);
        cyc(4'b0000, 3'b011);
        chk("t6.own0", 32'({gnt_b, id_b}), 32'({3'b001, 2'd0}));

        // random traffic with occasional asynchronous resets
        do_reset();
        ra = '0;
        rb = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NA; i++)
                if ($urandom_range(15) == 0) ra[i] = ~ra[i];
            for (int i = 0; i < NB; i++)
                if ($urandom_range(7) == 0) rb[i] = ~rb[i];
            if ($urandom_range(400) == 0) begin
                @(negedge clk);
                #2 rst = 1'b1;
                #10 rst = 1'b0;
            end
            cyc(ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
